idct_block_arbiter: RTL and testbench
=====================================

Name: idct_block_arbiter

Overview:
- Shares one wide row/column IDCT core between N_CH AXI-stream coefficient sources at 8x8-block granularity.
- Arbitration is round-robin, one full block (8 row beats) per grant; no preemption inside a block.
- Each granted channel ID is recorded in an in-order tag FIFO, so every output block from the core carries its originating channel on m_tdest.
- Sits between the per-channel input streams and the core's slave stream. The core's output stream passes through it to a shared master stream.

Parameters:
N_CH, 4, number of requester channels (>=2)
WIN, 12, bits per input coefficient
WOUT, 9, bits per output sample
TAG_DEPTH, 2, tag FIFO depth, power of two (max blocks in flight inside core)
CH_W, clog2(N_CH), localparam, channel ID width

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
s_tdata  in  N_CH*8*WIN  per-channel row of 8 coefficients, channel i at slice [i*8*WIN +: 8*WIN]
s_tvalid  in  N_CH  per-channel valid
s_tready  out  N_CH  per-channel ready
core_in_tdata  out  8*WIN  row to core
core_in_tvalid  out  1  valid to core
core_in_tready  in  1  core ready
core_out_tdata  in  8*WOUT  output row from core
core_out_tvalid  in  1  core output valid
core_out_tready  out  1  ready to core
m_tdata  out  8*WOUT  shared output row
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
m_tdest  out  CH_W  originating channel of current output block
m_tlast  out  1  high on 8th row of each output block
busy  out  1  grant active or tag FIFO non-empty
err_orphan  out  1  sticky: core produced data with empty tag FIFO

Behaviour:
- Reset (async assert, sync use of deassert) puts the block in the following state:
  - All outputs 0.
  - FSM = ARB.
  - last_grant = N_CH-1, so channel 0 has first priority.
  - beat counters = 0, tag FIFO empty, err_orphan = 0.
- Reset mid-block drops the partial block. The core shares reset_n and is reset with it.
- FSM ARB:
  - Arbitration condition: any s_tvalid high and tag FIFO not full.
  - When the condition holds, the block:
    - picks the first requesting channel searching (last_grant+1) mod N_CH upward with wrap;
    - registers it as grant;
    - pushes grant into the tag FIFO;
    - clears in_cnt;
    - moves to XFER.
  - ARB consumes exactly one cycle per grant. No beats are accepted in ARB.
  - All s_tready are 0 in ARB.
- FSM XFER:
  - core_in_tdata = s_tdata slice of grant.
  - core_in_tvalid = s_tvalid[grant].
  - s_tready[grant] = core_in_tready. All other s_tready are 0.
  - A beat is accepted when valid and ready are both high. in_cnt increments on each accepted beat.
  - On the accepted beat with in_cnt==7: last_grant <= grant, FSM -> ARB.
  - If the source deasserts tvalid mid-block, the grant is held indefinitely and other channels stay stalled.
- Output path (combinational pass-through, gated by tag FIFO):
  - m_tdata = core_out_tdata.
  - m_tvalid = core_out_tvalid & ~empty.
  - core_out_tready = m_tready & ~empty.
  - m_tdest = tag FIFO head. m_tdest is 0 when empty.
  - m_tlast = m_tvalid & (out_cnt==7).
  - out_cnt increments on each accepted output beat. On accepted beat 7 it wraps to 0 and the FIFO pops.
- Tag FIFO:
  - Pointer-based, with TAG_DEPTH entries.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - When full, the FIFO blocks further grants. This guarantees the core never holds more than TAG_DEPTH untagged blocks.
- err_orphan is set on any cycle with core_out_tvalid=1 and FIFO empty. It stays set until reset. No data moves in that cycle.
- busy = (FSM==XFER) | ~empty.
- Throughput at full rate: 9 input cycles per block (1 ARB + 8 beats).

Test Plan:
- Only ch2 sends 8 rows with tvalid held; core model echoes -> ARB 1 cycle; s_tready[2] high for 8 beats; other s_tready 0; 8 output rows with m_tdest=2; m_tlast on row 8 only.
- All 4 channels valid continuously, 6 blocks -> grant order 0,1,2,3,0,1; each grant followed by exactly 8 core_in beats; m_tdest sequence matches.
- m_tready=0 and core holds output, TAG_DEPTH=2 -> two blocks granted; third channel gets no grant (FSM stays ARB, busy=1) until m_tready=1 and the first output block's 8th beat pops the FIFO.
- ch1 granted; tvalid drops after beat 3 for 5 cycles while ch0/ch3 valid -> ch0/ch3 s_tready stay 0; block completes with 8 beats; next grant is ch3.
- core_out_tvalid=1 with empty FIFO -> m_tvalid=0, core_out_tready=0, err_orphan=1 and stays 1 until reset.
- Assert reset_n=0 asynchronously at beat 4 of a block -> all outputs 0 immediately; after release, ch0 is granted first and a fresh 8-beat block passes correctly.

Source files
------------

// File: rtl/idct_block_arbiter.sv
// -----------------------------------------------------------------------------
// idct_block_arbiter
//
// Shares one row/column IDCT core between N_CH AXI-stream coefficient sources.
// Grants are round-robin and cover one whole 8x8 block (8 row beats). A block
// is never preempted. Every grant pushes its channel ID into an in-order tag
// FIFO. The core's output stream passes through to a shared master stream
// that carries the originating channel on m_tdest.
//
// Ports:
//   clock, reset_n       single rising-edge clock, async active-low reset
//   s_tdata/s_tvalid/    per-channel input rows (channel i at slice
//   s_tready             [i*8*WIN +: 8*WIN])
//   core_in_*            row stream into the IDCT core
//   core_out_*           row stream out of the IDCT core
//   m_tdata/m_tvalid/    shared output stream; m_tdest = source channel,
//   m_tready/m_tdest/    m_tlast = 8th row of each block
//   m_tlast
//   busy                 grant in progress or blocks still inside the core
//   err_orphan           sticky: core produced data with no tag outstanding
//
// TAG_DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module idct_block_arbiter #(
   parameter int N_CH      = 4,
   parameter int WIN       = 12,
   parameter int WOUT      = 9,
   parameter int TAG_DEPTH = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [N_CH*8*WIN-1:0]         s_tdata,
   input  logic [N_CH-1:0]               s_tvalid,
   output logic [N_CH-1:0]               s_tready,
   output logic [8*WIN-1:0]              core_in_tdata,
   output logic                          core_in_tvalid,
   input  logic                          core_in_tready,
   input  logic [8*WOUT-1:0]             core_out_tdata,
   input  logic                          core_out_tvalid,
   output logic                          core_out_tready,
   output logic [8*WOUT-1:0]             m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [$clog2(N_CH)-1:0]       m_tdest,
   output logic                          m_tlast,
   output logic                          busy,
   output logic                          err_orphan
);

   localparam int CH_W = $clog2(N_CH);
   localparam int AW   = $clog2(TAG_DEPTH);

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t             r_state;
   logic [CH_W-1:0]    r_grant;
   logic [CH_W-1:0]    r_last_grant;
   logic [2:0]         r_in_cnt;
   logic [2:0]         r_out_cnt;
   logic [AW:0]        r_wr_ptr;
   logic [AW:0]        r_rd_ptr;
   logic [CH_W-1:0]    r_tag_mem [TAG_DEPTH];
   logic               r_err_orphan;

   logic               w_empty;
   logic               w_full;
   logic               w_found;
   logic [CH_W-1:0]    w_pick;
   logic [CH_W-1:0]    w_idx;
   logic               w_arb_go;
   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_pop;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // index with differing wrap bit means full.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Round-robin search starting one past the last completed grant.
   // NOTE: every signal written in an always_comb gets a default at the top,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 1; k <= N_CH; k++) begin
         w_idx = CH_W'((int'(r_last_grant) + k) % N_CH);
         if (!w_found && s_tvalid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_arb_go = (r_state == ST_ARB) && w_found && !w_full;

   // Input mux: only the granted channel sees the core's ready.
   always_comb begin
      s_tready       = '0;
      core_in_tdata  = '0;
      core_in_tvalid = 1'b0;
      if (r_state == ST_XFER) begin
         core_in_tdata     = s_tdata[int'(r_grant)*8*WIN +: 8*WIN];
         core_in_tvalid    = s_tvalid[r_grant];
         s_tready[r_grant] = core_in_tready;
      end
   end

   assign w_in_fire = core_in_tvalid & core_in_tready;

   // Output pass-through, blocked whenever no tag is outstanding so that
   // untagged core data can never reach the shared stream.
   assign m_tdata         = core_out_tdata;
   assign m_tvalid        = core_out_tvalid & ~w_empty;
   assign core_out_tready = m_tready & ~w_empty;
   assign m_tdest         = w_empty ? '0 : r_tag_mem[r_rd_ptr[AW-1:0]];
   assign m_tlast         = m_tvalid & (r_out_cnt == 3'd7);
   assign busy            = (r_state == ST_XFER) | ~w_empty;
   assign err_orphan      = r_err_orphan;

   assign w_out_fire = m_tvalid & m_tready;
   assign w_pop      = w_out_fire & (r_out_cnt == 3'd7);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_ARB;
         r_grant      <= '0;
         r_last_grant <= CH_W'(N_CH - 1);
         r_in_cnt     <= '0;
         r_out_cnt    <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_err_orphan <= 1'b0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_arb_go) begin
                  r_grant  <= w_pick;
                  r_in_cnt <= '0;
                  r_state  <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_in_fire) begin
                  r_in_cnt <= r_in_cnt + 3'd1;
                  if (r_in_cnt == 3'd7) begin
                     r_last_grant <= r_grant;
                     r_state      <= ST_ARB;
                  end
               end
            end
            default: r_state <= ST_ARB;
         endcase

         if (w_arb_go)
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         // 3-bit counter wraps to 0 on the 8th beat by itself.
         if (w_out_fire)
            r_out_cnt <= r_out_cnt + 3'd1;
         if (core_out_tvalid && w_empty)
            r_err_orphan <= 1'b1;
      end
   end

   // NOTE: tag storage has no reset; an entry is only read after it has been
   // written, and m_tdest is forced to 0 while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (w_arb_go)
         r_tag_mem[r_wr_ptr[AW-1:0]] <= w_pick;
   end

endmodule

// File: tb/tb_idct_block_arbiter.sv
// -----------------------------------------------------------------------------
// tb_idct_block_arbiter
//
// Directed bench for idct_block_arbiter (N_CH=4, WIN=12, WOUT=9, TAG_DEPTH=2).
// Sources emit rows whose coefficient j is {row[6:0], ch[1:0], j[2:0]}, so the
// channel is visible in bits [4:3] of both the input row and the core's output
// row. The core model is a buffered echo keeping the low 9 bits of each
// coefficient, with a one-cycle latency.
// -----------------------------------------------------------------------------
module tb_idct_block_arbiter;

   logic          clock;
   logic          reset_n;
   logic [383:0]  s_tdata;
   logic [3:0]    s_tvalid;
   logic [3:0]    s_tready;
   logic [95:0]   core_in_tdata;
   logic          core_in_tvalid;
   logic          core_in_tready;
   logic [71:0]   core_out_tdata;
   logic          core_out_tvalid;
   logic          core_out_tready;
   logic [71:0]   m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic [1:0]    m_tdest;
   logic          m_tlast;
   logic          busy;
   logic          err_orphan;

   int n_checks = 0;
   int n_errors = 0;

   idct_block_arbiter #(
      .N_CH(4), .WIN(12), .WOUT(9), .TAG_DEPTH(2)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .s_tdata         (s_tdata),
      .s_tvalid        (s_tvalid),
      .s_tready        (s_tready),
      .core_in_tdata   (core_in_tdata),
      .core_in_tvalid  (core_in_tvalid),
      .core_in_tready  (core_in_tready),
      .core_out_tdata  (core_out_tdata),
      .core_out_tvalid (core_out_tvalid),
      .core_out_tready (core_out_tready),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tdest         (m_tdest),
      .m_tlast         (m_tlast),
      .busy            (busy),
      .err_orphan      (err_orphan)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- sources ----------------
   int         src_sent [4];
   int         src_goal [4];
   logic [3:0] src_en;

   always_comb begin
      s_tvalid = '0;
      s_tdata  = '0;
      for (int i = 0; i < 4; i++) begin
         s_tvalid[i] = src_en[i] && (src_sent[i] < src_goal[i]);
         for (int j = 0; j < 8; j++)
            s_tdata[i*96 + j*12 +: 12] = {7'(src_sent[i]), 2'(i), 3'(j)};
      end
   end

   always @(posedge clock) begin
      for (int i = 0; i < 4; i++)
         if (s_tvalid[i] && s_tready[i])
            src_sent[i] <= src_sent[i] + 1;
   end

   // ---------------- core model ----------------
   logic [71:0] cmem [64];
   logic [7:0]  cw;
   logic [7:0]  cr;
   logic        force_orphan;
   logic [71:0] core_row;

   always_comb begin
      core_row = '0;
      for (int j = 0; j < 8; j++)
         core_row[j*9 +: 9] = core_in_tdata[j*12 +: 9];
   end

   assign core_in_tready  = 1'b1;
   assign core_out_tvalid = force_orphan | (cw != cr);
   assign core_out_tdata  = (cw != cr) ? cmem[cr[5:0]] : '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cw <= '0;
         cr <= '0;
      end else begin
         if (core_in_tvalid && core_in_tready) begin
            cmem[cw[5:0]] <= core_row;
            cw <= cw + 8'd1;
         end
         if (core_out_tvalid && core_out_tready && (cw != cr))
            cr <= cr + 8'd1;
      end
   end

   // ---------------- monitors ----------------
   int         in_n;
   int         out_n;
   logic [1:0] in_ch    [256];
   logic [1:0] out_dest [256];
   logic [1:0] out_ch   [256];
   logic       out_last [256];

   always @(posedge clock) begin
      if (core_in_tvalid && core_in_tready && in_n < 256) begin
         in_ch[in_n] <= core_in_tdata[4:3];
         in_n        <= in_n + 1;
      end
      if (m_tvalid && m_tready && out_n < 256) begin
         out_dest[out_n] <= m_tdest;
         out_ch[out_n]   <= m_tdata[4:3];
         out_last[out_n] <= m_tlast;
         out_n           <= out_n + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_s_tready"},        s_tready,        0);
      check({pfx, "_core_in_tvalid"},  core_in_tvalid,  0);
      check({pfx, "_core_in_tdata"},   core_in_tdata,   0);
      check({pfx, "_core_out_tready"}, core_out_tready, 0);
      check({pfx, "_m_tvalid"},        m_tvalid,        0);
      check({pfx, "_m_tdata"},         m_tdata,         0);
      check({pfx, "_m_tdest"},         m_tdest,         0);
      check({pfx, "_m_tlast"},         m_tlast,         0);
      check({pfx, "_busy"},            busy,            0);
      check({pfx, "_err_orphan"},      err_orphan,      0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic wait_out(input string tag, input int target);
      int k = 0;
      while (out_n < target && k < 400) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_drain"}, out_n, target);
   endtask

   task automatic wait_src(input string tag, input int ch, input int target);
      int k = 0;
      while (src_sent[ch] != target && k < 200) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_src_progress"}, src_sent[ch], target);
   endtask

   task automatic check_block(input string tag, input int idx, input int ch);
      for (int r = 0; r < 8; r++) begin
         check($sformatf("%s_r%0d_dest", tag, r), out_dest[idx+r], ch);
         check($sformatf("%s_r%0d_data_ch", tag, r), out_ch[idx+r], ch);
         check($sformatf("%s_r%0d_last", tag, r), out_last[idx+r], (r == 7));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int b_out;
      int b_in;
      int b_src;
      int n_rdy;
      int n_other;
      int exp_order [6];

      reset_n      = 1'b1;
      m_tready     = 1'b1;
      force_orphan = 1'b0;
      src_en       = 4'hF;
      for (int i = 0; i < 4; i++) src_goal[i] = 0;

      // Reset state.
      #2 reset_n = 1'b0;
      #1 check_all_zero("rst");
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_all_zero("rst_idle");

      // Test 1: only ch2 sends one block.
      b_out = out_n;
      src_goal[2] = src_sent[2] + 8;
      #1;
      check("t1_arb_s_tready", s_tready, 0);
      check("t1_arb_core_in_tvalid", core_in_tvalid, 0);
      @(negedge clock);
      check("t1_xfer_s_tready", s_tready, 4'b0100);
      check("t1_xfer_busy", busy, 1);
      n_rdy = 1;
      n_other = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (s_tready == 4'b0000) break;
         n_rdy++;
         if (s_tready != 4'b0100) n_other++;
      end
      check("t1_ready_beats", n_rdy, 8);
      check("t1_other_ready", n_other, 0);
      wait_out("t1", b_out + 8);
      check_block("t1", b_out, 2);

      // Test 2: all channels busy, six blocks in round-robin order.
      do_reset();
      b_out = out_n;
      b_in  = in_n;
      src_goal[0] = src_sent[0] + 16;
      src_goal[1] = src_sent[1] + 16;
      src_goal[2] = src_sent[2] + 8;
      src_goal[3] = src_sent[3] + 8;
      exp_order = '{0, 1, 2, 3, 0, 1};
      wait_out("t2", b_out + 48);
      check("t2_in_beats", in_n - b_in, 48);
      for (int b = 0; b < 6; b++) begin
         for (int r = 0; r < 8; r++)
            check($sformatf("t2_b%0d_r%0d_in_ch", b, r),
                  in_ch[b_in + b*8 + r], exp_order[b]);
         check_block($sformatf("t2_b%0d", b), b_out + b*8, exp_order[b]);
      end

      // Test 3: output stalled, tag FIFO fills after two blocks.
      do_reset();
      m_tready = 1'b0;
      b_out = out_n;
      b_in  = in_n;
      b_src = src_sent[2];
      src_goal[0] = src_sent[0] + 8;
      src_goal[1] = src_sent[1] + 8;
      src_goal[2] = src_sent[2] + 8;
      for (int c = 0; c < 40; c++) @(negedge clock);
      check("t3_in_beats_blocked", in_n - b_in, 16);
      check("t3_ch2_not_sent", src_sent[2], b_src);
      check("t3_stall_s_tready", s_tready, 0);
      check("t3_stall_core_in_tvalid", core_in_tvalid, 0);
      check("t3_stall_busy", busy, 1);
      check("t3_stall_m_tvalid", m_tvalid, 1);
      check("t3_stall_m_tdest", m_tdest, 0);
      check("t3_stall_m_tlast", m_tlast, 0);
      m_tready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         check($sformatf("t3_drain%0d_s_tready", i), s_tready, 0);
         if (i == 7) check("t3_drain7_m_tlast", m_tlast, 1);
      end
      @(negedge clock);
      check("t3_ch2_granted", s_tready, 4'b0100);
      wait_out("t3", b_out + 24);
      check_block("t3_b0", b_out,      0);
      check_block("t3_b1", b_out + 8,  1);
      check_block("t3_b2", b_out + 16, 2);

      // Test 4: ch1 pauses mid-block; others must stay stalled.
      do_reset();
      b_out = out_n;
      b_in  = in_n;
      b_src = src_sent[1];
      src_goal[1] = src_sent[1] + 8;
      @(negedge clock);
      check("t4_ch1_granted", s_tready, 4'b0010);
      src_goal[0] = src_sent[0] + 8;
      src_goal[3] = src_sent[3] + 8;
      wait_src("t4_b3", 1, b_src + 3);
      src_en[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         check($sformatf("t4_pause%0d_s_tready", c), s_tready, 4'b0010);
         check($sformatf("t4_pause%0d_core_in_tvalid", c), core_in_tvalid, 0);
      end
      @(negedge clock);
      src_en[1] = 1'b1;
      wait_src("t4_b8", 1, b_src + 8);
      check("t4_arb_s_tready", s_tready, 0);
      @(negedge clock);
      check("t4_next_is_ch3", s_tready, 4'b1000);
      wait_out("t4", b_out + 24);
      check("t4_in_beats", in_n - b_in, 24);
      check_block("t4_b0", b_out,      1);
      check_block("t4_b1", b_out + 8,  3);
      check_block("t4_b2", b_out + 16, 0);

      // Test 5: orphan core output with empty tag FIFO.
      @(negedge clock);
      @(negedge clock);
      check("t5_idle_busy", busy, 0);
      force_orphan = 1'b1;
      #1;
      check("t5_m_tvalid", m_tvalid, 0);
      check("t5_core_out_tready", core_out_tready, 0);
      check("t5_err_before_edge", err_orphan, 0);
      @(negedge clock);
      check("t5_err_set", err_orphan, 1);
      force_orphan = 1'b0;
      for (int c = 0; c < 3; c++) @(negedge clock);
      check("t5_err_sticky", err_orphan, 1);
      check("t5_m_tvalid_after", m_tvalid, 0);

      // Test 6: asynchronous reset in the middle of a block.
      do_reset();
      @(negedge clock);
      check("t6_err_cleared", err_orphan, 0);
      b_src = src_sent[2];
      src_goal[2] = src_sent[2] + 8;
      wait_src("t6_b4", 2, b_src + 4);
      #2 reset_n = 1'b0;
      #1 check_all_zero("t6_async_rst");
      src_goal[2] = src_sent[2];
      src_goal[0] = src_sent[0] + 8;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      b_out = out_n;
      b_in  = in_n;
      @(negedge clock);
      check("t6_ch0_first", s_tready, 4'b0001);
      wait_out("t6", b_out + 8);
      check("t6_in_beats", in_n - b_in, 8);
      for (int r = 0; r < 8; r++)
         check($sformatf("t6_r%0d_in_ch", r), in_ch[b_in + r], 0);
      check_block("t6", b_out, 0);
      @(negedge clock);
      @(negedge clock);
      check("t6_idle_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
